// File: rtl/decoder_addr_seq.sv
// decoder_addr_seq: address sequencer feeding the A input of the 5-to-32
// one-hot decoder. On start it walks base, base+stride, ... (mod 2^ADDR_W)
// for `count` addresses, one per accepted transfer, honouring a downstream
// stall. Progress is reported by busy, issued and a one-cycle done pulse.
// All outputs are registered; the next-state logic is a single
// combinational process feeding one register bank.

module decoder_addr_seq #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [CNT_W-1:0]  count,
  input  logic              stall,
  output logic [ADDR_W-1:0] A,
  output logic              a_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  issued
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  // Registered state
  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic              valid_r;
  logic              busy_r;
  logic              done_r;
  logic [CNT_W-1:0]  issued_r;
  logic [ADDR_W-1:0] stride_r;
  logic [CNT_W-1:0]  remaining_r;

  // Next-state values
  state_t            state_s;
  logic [ADDR_W-1:0] addr_s;
  logic              valid_s;
  logic              busy_s;
  logic              done_s;
  logic [CNT_W-1:0]  issued_s;
  logic [ADDR_W-1:0] stride_s;
  logic [CNT_W-1:0]  remaining_s;

  // A transfer happens whenever a live address meets a non-stalled consumer.
  logic transfer_s;
  assign transfer_s = valid_r & ~stall;

  // Next-state and output computation; everything holds unless a rule fires.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    valid_s     = valid_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    issued_s    = issued_r;
    stride_s    = stride_r;
    remaining_s = remaining_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          // A new run always resets the progress counter.
          issued_s = CNT_ZERO;
          if (count != CNT_ZERO) begin
            state_s     = RUN;
            addr_s      = base;
            valid_s     = 1'b1;
            busy_s      = 1'b1;
            stride_s    = stride;
            remaining_s = count;
          end else begin
            // Empty run: report completion without ever presenting an address.
            done_s = 1'b1;
          end
        end else begin
          valid_s = 1'b0;
          busy_s  = 1'b0;
        end
      end

      RUN: begin
        // start is deliberately ignored here, including on the last transfer.
        if (transfer_s) begin
          issued_s = issued_r + CNT_ONE;
          if (remaining_r > CNT_ONE) begin
            addr_s      = addr_r + stride_r;
            remaining_s = remaining_r - CNT_ONE;
          end else begin
            // Final address consumed: A keeps the last address for observation.
            state_s     = IDLE;
            valid_s     = 1'b0;
            busy_s      = 1'b0;
            done_s      = 1'b1;
            remaining_s = CNT_ZERO;
          end
        end else begin
          // Stalled (or defensively, no live address): hold everything.
          remaining_s = remaining_r;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a quiet idle.
        state_s     = IDLE;
        valid_s     = 1'b0;
        busy_s      = 1'b0;
        remaining_s = CNT_ZERO;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= ADDR_ZERO;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      issued_r    <= CNT_ZERO;
      stride_r    <= ADDR_ZERO;
      remaining_r <= CNT_ZERO;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      valid_r     <= valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      issued_r    <= issued_s;
      stride_r    <= stride_s;
      remaining_r <= remaining_s;
    end
  end

  assign A       = addr_r;
  assign a_valid = valid_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign issued  = issued_r;

endmodule

// File: tb/tb_decoder_addr_seq.sv
// Self-checking bench for decoder_addr_seq. Expected addresses come from the
// closed form (base + i*stride) mod 32; the bench counts transfers itself.

module tb_decoder_addr_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] base;
  logic [4:0] stride;
  logic [5:0] count;
  logic       stall;
  logic [4:0] A;
  logic       a_valid;
  logic       busy;
  logic       done;
  logic [5:0] issued;

  int checks = 0;
  int errors = 0;
  logic [4:0] last_a;

  decoder_addr_seq #(.ADDR_W(5), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .stride(stride),
    .count(count), .stall(stall), .A(A), .a_valid(a_valid), .busy(busy),
    .done(done), .issued(issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address i of a run, computed directly from the arithmetic definition.
  function automatic logic [4:0] exp_addr(input int b, input int s, input int i);
    return 5'((b + i * s) % 32);
  endfunction

  // Launch one run and follow it cycle by cycle.
  // stall_mode: 0 none, 1 random, 2 two stall cycles while the second address is shown.
  task automatic do_run(input int b, input int s, input int c, input int stall_mode,
                        input bit noise, input bit chain);
    int idx = 0;
    int cyc = 0;
    int held = 0;
    bit st;
    start  = 1'b1;
    base   = 5'(b);
    stride = 5'(s);
    count  = 6'(c);
    stall  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (idx < c && cyc < 300) begin
      checks++;
      if (a_valid !== 1'b1 || A !== exp_addr(b, s, idx) || issued !== 6'(idx) ||
          busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL run_step idx=%0d: got A=%0d a_valid=%b issued=%0d busy=%b done=%b, want A=%0d a_valid=1 issued=%0d busy=1 done=0",
                 idx, A, a_valid, issued, busy, done, exp_addr(b, s, idx), idx);
      end
      case (stall_mode)
        1: st = ($urandom_range(0, 2) == 0);
        2: begin
          st = (idx == 1 && held < 2);
          if (st) held++;
        end
        default: st = 1'b0;
      endcase
      stall = st;
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        base   = 5'($urandom);
        stride = 5'($urandom);
        count  = 6'($urandom_range(0, 32));
      end
      @(posedge clk); #1;
      if (!st) idx++;
      cyc++;
    end
    start = 1'b0;
    stall = 1'b0;
    checks++;
    if (cyc >= 300) begin
      errors++;
      $display("FAIL run_timeout: got %0d transfers after %0d cycles, want %0d", idx, cyc, c);
    end
    checks++;
    if (a_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || issued !== 6'(c) ||
        A !== exp_addr(b, s, c - 1)) begin
      errors++;
      $display("FAIL run_end: got A=%0d a_valid=%b busy=%b done=%b issued=%0d, want A=%0d a_valid=0 busy=0 done=1 issued=%0d",
               A, a_valid, busy, done, issued, exp_addr(b, s, c - 1), c);
    end
    last_a = exp_addr(b, s, c - 1);
    if (!chain) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || a_valid !== 1'b0 || A !== last_a || issued !== 6'(c)) begin
        errors++;
        $display("FAIL run_after: got done=%b a_valid=%b A=%0d issued=%0d, want done=0 a_valid=0 A=%0d issued=%0d",
                 done, a_valid, A, issued, last_a, c);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    base = 5'd9; stride = 5'd1; count = 6'd5; stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (A !== 5'd0 || a_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || issued !== 6'd0) begin
        errors++;
        $display("FAIL reset_hold: got A=%0d a_valid=%b busy=%b done=%b issued=%0d, want all 0",
                 A, a_valid, busy, done, issued);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got a_valid=%b busy=%b done=%b, want 0 0 0", a_valid, busy, done);
    end
    last_a = 5'd0;
  endtask

  task automatic test_basic;
    do_run(1, 1, 4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap;
    do_run(30, 3, 3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall;
    do_run(0, 1, 3, 2, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_start;
    do_run(6, 5, 7, 0, 1'b1, 1'b0);
  endtask

  task automatic test_zero_count;
    start = 1'b1; base = 5'd17; stride = 5'd2; count = 6'd0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || a_valid !== 1'b0 || busy !== 1'b0 || issued !== 6'd0 || A !== last_a) begin
      errors++;
      $display("FAIL zero_count: got done=%b a_valid=%b busy=%b issued=%0d A=%0d, want 1 0 0 0 A=%0d",
               done, a_valid, busy, issued, A, last_a);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || a_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_count_after: got done=%b a_valid=%b, want 0 0", done, a_valid);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    start = 1'b1; base = 5'd5; stride = 5'd2; count = 6'd8; stall = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (a_valid !== 1'b1 || A !== exp_addr(5, 2, i)) begin
        errors++;
        $display("FAIL midrun_addr: got A=%0d a_valid=%b, want A=%0d a_valid=1", A, a_valid, exp_addr(5, 2, i));
      end
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (A !== 5'd0 || a_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || issued !== 6'd0) begin
      errors++;
      $display("FAIL midrun_reset: got A=%0d a_valid=%b busy=%b done=%b issued=%0d, want all 0",
               A, a_valid, busy, done, issued);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_done: got done=%b a_valid=%b, want 0 0", done, a_valid);
    end
    last_a = 5'd0;
    do_run(7, 3, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    do_run(3, 7, 5, 0, 1'b0, 1'b1);
    do_run(20, 1, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 20; r++) begin
      do_run(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(1, 32)), 1, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; base = 5'd0; stride = 5'd0; count = 6'd0; stall = 1'b0;
    last_a = 5'd0;
    #2;
    test_reset;
    test_basic;
    test_wrap;
    test_stall;
    test_ignored_start;
    test_zero_count;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
